// File: rtl/bypass_mem_responder.sv
// Bypass-interface responder bridging one uncached dcache request to a single-beat req/gnt memory port.
// Optional response timeout in MEM_WAIT enabled by defining BYPASS_RSP_TIMEOUT_EN.

package std_cache_pkg;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BE_W   = 8;
    localparam int unsigned ID_W   = 4;

    typedef enum logic [3:0] {
        AMO_NONE = 4'h0,
        AMO_LR   = 4'h1,
        AMO_SC   = 4'h2,
        AMO_SWAP = 4'h3,
        AMO_ADD  = 4'h4,
        AMO_AND  = 4'h5,
        AMO_OR   = 4'h6,
        AMO_XOR  = 4'h7,
        AMO_MAX  = 4'h8,
        AMO_MAXU = 4'h9,
        AMO_MIN  = 4'hA,
        AMO_MINU = 4'hB,
        AMO_CAS1 = 4'hC,
        AMO_CAS2 = 4'hD
    } amo_t;

    typedef enum logic {
        SINGLE_REQ     = 1'b0,
        CACHE_LINE_REQ = 1'b1
    } req_type_t;

    typedef struct packed {
        logic              req;
        req_type_t         reqtype;
        amo_t              amo;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [1:0]        size;
    } bypass_req_t;

    typedef struct packed {
        logic              gnt;
        logic              valid;
        logic [DATA_W-1:0] rdata;
    } bypass_rsp_t;
endpackage

module bypass_mem_responder
`ifdef BYPASS_RSP_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
)
`endif
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  std_cache_pkg::bypass_req_t bypass_req_i,
    output std_cache_pkg::bypass_rsp_t bypass_rsp_o,
    output logic                       mem_req_o,
    input  logic                       mem_gnt_i,
    output logic                       mem_we_o,
    output logic [63:0]                mem_addr_o,
    output logic [63:0]                mem_wdata_o,
    output logic [7:0]                 mem_be_o,
    input  logic                       mem_rvalid_i,
    input  logic [63:0]                mem_rdata_i,
    output logic                       err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  be_q, be_d;
    logic [63:0] rdata_q, rdata_d;
    logic        gnt_c;
    logic [7:0]  rd_base_c;
    logic [7:0]  rd_mask_c;

`ifdef BYPASS_RSP_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Ordering is implied by the single outstanding transaction, so id/reqtype are not needed.
    logic unused_req_bits;
    assign unused_req_bits = ^{bypass_req_i.id, bypass_req_i.reqtype};

    // Read lane mask; lanes shifted past byte 7 are dropped.
    always_comb begin
        rd_base_c = 8'h01;
        case (bypass_req_i.size)
            2'd0:    rd_base_c = 8'h01;
            2'd1:    rd_base_c = 8'h03;
            2'd2:    rd_base_c = 8'h0F;
            default: rd_base_c = 8'hFF;
        endcase
        rd_mask_c = 8'(16'(rd_base_c) << bypass_req_i.addr[2:0]);
    end

    always_comb begin
        state_d = state_q;
        gnt_c   = 1'b0;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
`ifdef BYPASS_RSP_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_c = bypass_req_i.req;
                if (bypass_req_i.req) begin
                    we_d    = bypass_req_i.we;
                    addr_d  = {bypass_req_i.addr[63:3], 3'b000};
                    wdata_d = bypass_req_i.wdata;
                    be_d    = bypass_req_i.we ? bypass_req_i.be : rd_mask_c;
                    if (bypass_req_i.amo != std_cache_pkg::AMO_NONE) begin
                        rdata_d = '1;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                if (mem_gnt_i) begin
                    if (mem_rvalid_i) begin
                        rdata_d = we_q ? '0 : mem_rdata_i;
                        state_d = RESP;
                    end else begin
                        state_d = MEM_WAIT;
`ifdef BYPASS_RSP_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_rvalid_i) begin
                    rdata_d = we_q ? '0 : mem_rdata_i;
                    state_d = RESP;
                end
`ifdef BYPASS_RSP_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Output flags follow the state being entered, so they are flop outputs.
        mem_req_d = (state_d == MEM_REQ);
        valid_d   = (state_d == RESP);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
`ifdef BYPASS_RSP_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
`ifdef BYPASS_RSP_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_be_o     = be_q;
    assign err_o        = err_q;
    assign bypass_rsp_o = '{gnt: gnt_c, valid: valid_q, rdata: rdata_q};

endmodule
